single_multiplier: RTL and testbench

- IEEE-754 single-precision floating-point multiplier: z = a × b.
- Operands and result are exchanged over independent stb/ack handshakes, one transfer per port.
- Sequential multi-cycle FSM: one operation in flight at a time.
- Standalone arithmetic leaf used by higher-level datapath blocks that need one FP multiply at a time.

---
 rtl/fp32_pkg.sv | 28 ++
 rtl/fp32_unpack.sv | 32 +++
 rtl/single_multiplier.sv | 252 +++++++++++++++++++++++++
 tb/tb_single_multiplier.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions: field widths, canonical constants and the multiplier FSM states.
package fp32_pkg;

  localparam int unsigned ExpW  = 8;
  localparam int unsigned FracW = 23;
  localparam int unsigned MantW = 24;
  localparam int          Bias  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [3:0] {
    GetA,
    GetB,
    Unpack,
    Special,
    NormA,
    NormB,
    Mul0,
    Mul1,
    Norm1,
    Norm2,
    Round,
    Pack,
    PutZ
  } state_e;

endpackage

// File: rtl/fp32_unpack.sv
// Splits a binary32 word into sign, unbiased exponent and mantissa, and classifies it.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic              sign_o,
  output logic signed [9:0] exp_o,
  output logic [MantW-1:0]  mant_o,
  output logic              is_zero_o,
  output logic              is_inf_o,
  output logic              is_nan_o,
  output logic              is_denorm_o
);

  logic [ExpW-1:0]  exp_field;
  logic [FracW-1:0] frac_field;

  assign exp_field  = op_i[30:23];
  assign frac_field = op_i[FracW-1:0];

  // Field split and classification; the hidden bit is added later by the consumer.
  always_comb begin
    sign_o      = op_i[31];
    exp_o       = $signed({2'b00, exp_field}) - 10'sd127;
    mant_o      = {1'b0, frac_field};
    is_zero_o   = (exp_field == '0) && (frac_field == '0);
    is_denorm_o = (exp_field == '0) && (frac_field != '0);
    is_inf_o    = (exp_field == '1) && (frac_field == '0);
    is_nan_o    = (exp_field == '1) && (frac_field != '0);
  end

endmodule

// File: rtl/single_multiplier.sv
// Multi-cycle binary32 multiplier with stb/ack handshakes on each operand and the result.
module single_multiplier
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
  logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic               guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic [47:0]        product_q, product_d;
  logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

  logic              ua_sign, ub_sign;
  logic signed [9:0] ua_exp, ub_exp;
  logic [23:0]       ua_mant, ub_mant;
  logic              ua_zero, ua_inf, ua_nan, ua_denorm;
  logic              ub_zero, ub_inf, ub_nan, ub_denorm;
  logic signed [9:0] biased_e;

  fp32_unpack u_unpack_a (
    .op_i        (a_q),
    .sign_o      (ua_sign),
    .exp_o       (ua_exp),
    .mant_o      (ua_mant),
    .is_zero_o   (ua_zero),
    .is_inf_o    (ua_inf),
    .is_nan_o    (ua_nan),
    .is_denorm_o (ua_denorm)
  );

  fp32_unpack u_unpack_b (
    .op_i        (b_q),
    .sign_o      (ub_sign),
    .exp_o       (ub_exp),
    .mant_o      (ub_mant),
    .is_zero_o   (ub_zero),
    .is_inf_o    (ub_inf),
    .is_nan_o    (ub_nan),
    .is_denorm_o (ub_denorm)
  );

  assign biased_e     = z_e_q + 10'sd127;
  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

  // Next-state and datapath updates, one FSM step per cycle.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    a_m_d     = a_m_q;
    b_m_d     = b_m_q;
    z_m_d     = z_m_q;
    a_e_d     = a_e_q;
    b_e_d     = b_e_q;
    z_e_d     = z_e_q;
    a_s_d     = a_s_q;
    b_s_d     = b_s_q;
    z_s_d     = z_s_q;
    guard_d   = guard_q;
    round_d   = round_q;
    sticky_d  = sticky_q;
    product_d = product_q;
    a_ack_d   = a_ack_q;
    b_ack_d   = b_ack_q;
    z_stb_d   = z_stb_q;

    unique case (state_q)
      GetA: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          a_ack_d = 1'b0;
          state_d = GetB;
        end
      end
      GetB: begin
        b_ack_d = 1'b1;
        if (b_ack_q && input_b_stb) begin
          b_d     = input_b;
          b_ack_d = 1'b0;
          state_d = Unpack;
        end
      end
      Unpack: begin
        a_s_d   = ua_sign;
        a_e_d   = ua_exp;
        a_m_d   = ua_mant;
        b_s_d   = ub_sign;
        b_e_d   = ub_exp;
        b_m_d   = ub_mant;
        state_d = Special;
      end
      Special: begin
        state_d = PutZ;
        if (ua_nan || ub_nan) begin
          z_d = QNAN;
        end else if ((ua_inf && ub_zero) || (ub_inf && ua_zero)) begin
          z_d = QNAN;
        end else if (ua_inf || ub_inf) begin
          z_d = POS_INF | {a_s_q ^ b_s_q, 31'd0};
        end else if (ua_zero || ub_zero) begin
          z_d = {a_s_q ^ b_s_q, 31'd0};
        end else begin
          // Denormals sit at the minimum exponent without a hidden bit.
          if (ua_denorm) a_e_d = -10'sd126;
          else           a_m_d[23] = 1'b1;
          if (ub_denorm) b_e_d = -10'sd126;
          else           b_m_d[23] = 1'b1;
          state_d = NormA;
        end
      end
      NormA: begin
        if (a_m_q[23]) begin
          state_d = NormB;
        end else begin
          a_m_d = a_m_q << 1;
          a_e_d = a_e_q - 10'sd1;
        end
      end
      NormB: begin
        if (b_m_q[23]) begin
          state_d = Mul0;
        end else begin
          b_m_d = b_m_q << 1;
          b_e_d = b_e_q - 10'sd1;
        end
      end
      Mul0: begin
        z_s_d     = a_s_q ^ b_s_q;
        z_e_d     = a_e_q + b_e_q + 10'sd1;
        product_d = {24'd0, a_m_q} * {24'd0, b_m_q};
        state_d   = Mul1;
      end
      Mul1: begin
        z_m_d    = product_q[47:24];
        guard_d  = product_q[23];
        round_d  = product_q[22];
        sticky_d = |product_q[21:0];
        state_d  = Norm1;
      end
      Norm1: begin
        if (!z_m_q[23]) begin
          z_e_d   = z_e_q - 10'sd1;
          z_m_d   = {z_m_q[22:0], guard_q};
          guard_d = round_q;
          round_d = 1'b0;
        end else begin
          state_d = Norm2;
        end
      end
      Norm2: begin
        // Shift right into the denormal range, keeping the discarded bits in guard/round/sticky.
        if (z_e_q < -10'sd126) begin
          z_e_d    = z_e_q + 10'sd1;
          z_m_d    = z_m_q >> 1;
          guard_d  = z_m_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
        end else begin
          state_d = Round;
        end
      end
      Round: begin
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFF_FFFF) z_e_d = z_e_q + 10'sd1;
        end
        state_d = Pack;
      end
      Pack: begin
        z_d = {z_s_q, biased_e[7:0], z_m_q[22:0]};
        if ((z_e_q == -10'sd126) && !z_m_q[23]) z_d[30:23] = 8'd0;
        if (z_e_q > 10'sd127) z_d = {z_s_q, 8'hFF, 23'd0};
        state_d = PutZ;
      end
      PutZ: begin
        z_stb_d = 1'b1;
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GetA;
        end
      end
      default: state_d = GetA;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GetA;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= '0;
      a_m_q     <= '0;
      b_m_q     <= '0;
      z_m_q     <= '0;
      a_e_q     <= '0;
      b_e_q     <= '0;
      z_e_q     <= '0;
      a_s_q     <= 1'b0;
      b_s_q     <= 1'b0;
      z_s_q     <= 1'b0;
      guard_q   <= 1'b0;
      round_q   <= 1'b0;
      sticky_q  <= 1'b0;
      product_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      z_stb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      z_q       <= z_d;
      a_m_q     <= a_m_d;
      b_m_q     <= b_m_d;
      z_m_q     <= z_m_d;
      a_e_q     <= a_e_d;
      b_e_q     <= b_e_d;
      z_e_q     <= z_e_d;
      a_s_q     <= a_s_d;
      b_s_q     <= b_s_d;
      z_s_q     <= z_s_d;
      guard_q   <= guard_d;
      round_q   <= round_d;
      sticky_q  <= sticky_d;
      product_q <= product_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      z_stb_q   <= z_stb_d;
    end
  end

endmodule

// File: tb/tb_single_multiplier.sv
// Scoreboard bench for single_multiplier: driver pushes expected products, monitor pops and compares.
module tb_single_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] input_b = '0;
  logic        input_b_stb = 1'b0;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          n_out = 0;
  logic [31:0] exp_q[$];

  single_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send_a(input logic [31:0] v);
    bit done = 0;
    input_a     = v;
    input_a_stb = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      if (input_a_ack) done = 1;
    end
    #1 input_a_stb = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL a_handshake: got no ack, expected ack for %h", v);
    end
  endtask

  task automatic send_b(input logic [31:0] v);
    bit done = 0;
    input_b     = v;
    input_b_stb = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      if (input_b_ack) done = 1;
    end
    #1 input_b_stb = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL b_handshake: got no ack, expected ack for %h", v);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
    exp_q.push_back(z);
    send_a(a);
    send_b(b);
  endtask

  // Monitor: hold off ack briefly so result stability is observed, then compare and consume.
  initial begin
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (!rst && output_z_stb) begin
        got = output_z;
        repeat (2) @(negedge clk);
        check($sformatf("hold_%0d", n_out), {31'd0, output_z_stb && (output_z == got)}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, expected no output", got);
        end else begin
          check($sformatf("result_%0d", n_out), got, exp_q.pop_front());
        end
        n_out++;
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
      end
    end
  end

  logic [31:0] sp_a[7] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h0000_0001,
                           32'h7FA0_0000, 32'h8000_0000, 32'h3FC0_0000};
  logic [31:0] sp_b[7] = '{32'h0000_0000, 32'hC000_0000, 32'h4000_0000, 32'h3F80_0000,
                           32'h3F80_0000, 32'h3F80_0000, 32'h3FC0_0000};
  logic [31:0] sp_z[7] = '{32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000, 32'h0000_0001,
                           32'h7FC0_0000, 32'h8000_0000, 32'h4010_0000};

  initial begin
    bit stb_seen;
    // Reset held while operands are offered: nothing may be accepted or produced.
    input_a = 32'h4000_0000; input_a_stb = 1'b1;
    input_b = 32'h4040_0000; input_b_stb = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
    check("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
    check("rst_z", output_z, 32'd0);
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    rst = 1'b0;

    // No A offered: waits in GET_A with ack raised.
    repeat (8) @(negedge clk);
    check("a_stall_ack", {31'd0, input_a_ack}, 32'd1);
    check("a_stall_z_stb", {31'd0, output_z_stb}, 32'd0);

    op(32'hCF90_0000, 32'hCD9E_0000, 32'h5DB1_C000);
    op(32'h4144_CCCD, 32'h4165_851F, 32'h4330_718A);
    op(32'hBE16_0000, 32'h3C60_0000, 32'hBB03_4000);

    // A accepted, B withheld: waits in GET_B.
    exp_q.push_back(32'h40C0_0000);
    send_a(32'h4000_0000);
    repeat (8) @(negedge clk);
    check("b_stall_ack", {31'd0, input_b_ack}, 32'd1);
    check("b_stall_z_stb", {31'd0, output_z_stb}, 32'd0);
    send_b(32'h4040_0000);

    for (int i = 0; i < 7; i++) op(sp_a[i], sp_b[i], sp_z[i]);

    // Reset mid-multiply: operation aborted, FSM back in GET_A, no result.
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    send_a(32'h4144_CCCD);
    send_b(32'h4165_851F);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_z_stb", {31'd0, output_z_stb}, 32'd0);
    check("midrst_b_ack", {31'd0, input_b_ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stb_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (output_z_stb) stb_seen = 1;
    end
    check("midrst_no_output", {31'd0, stb_seen}, 32'd0);
    check("midrst_a_ack", {31'd0, input_a_ack}, 32'd1);

    op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d outstanding, expected 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
